// File: rtl/eth_frame_receiver_if.sv
// ---------------------------------------------------------------------------
// eth_frame_receiver_if
// Purpose : groups the byte-stream input and the parsed-frame outputs of the
//           Ethernet frame receiver into one bundle.
// Signals : rx_data/rx_valid      - received byte stream (into the receiver)
//           dest_addr/src_addr    - 48-bit addresses of last accepted frame
//           eth_type/payload      - EtherType and 4-byte payload
//           frame_ok/crc_err/addr_drop/frame_abort - one-cycle verdict pulses
//           rx_busy               - receiver is inside a frame
// Modports: master drives the byte stream, slave is the receiver.
// ---------------------------------------------------------------------------
interface eth_frame_receiver_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [47:0] dest_addr;
  logic [47:0] src_addr;
  logic [15:0] eth_type;
  logic [31:0] payload;
  logic        frame_ok;
  logic        crc_err;
  logic        addr_drop;
  logic        frame_abort;
  logic        rx_busy;

  modport master (
    output rx_data, rx_valid,
    input  dest_addr, src_addr, eth_type, payload,
    input  frame_ok, crc_err, addr_drop, frame_abort, rx_busy
  );

  modport slave (
    input  rx_data, rx_valid,
    output dest_addr, src_addr, eth_type, payload,
    output frame_ok, crc_err, addr_drop, frame_abort, rx_busy
  );
endinterface

// File: rtl/eth_frame_receiver.sv
// ---------------------------------------------------------------------------
// eth_frame_receiver
// Purpose : hunts for preamble/SFD on a byte stream, captures destination,
//           source, EtherType and a 4-byte payload, checks the trailing FCS
//           against a running CRC-32, filters on destination address and
//           presents accepted frames as parallel fields with a strobe.
// Ports   : clk    - rising-edge clock
//           rst_n  - asynchronous active-low reset
//           rx_if  - slave side of eth_frame_receiver_if (byte stream in,
//                    frame fields and verdict pulses out, all registered)
// ---------------------------------------------------------------------------
module eth_frame_receiver #(
  parameter logic [47:0] MAC_ADDR     = 48'hAA_BB_CC_DD_EE_FF,
  parameter int unsigned PREAMBLE_MIN = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  eth_frame_receiver_if.slave  rx_if
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PRE     = 3'd1;
  localparam logic [2:0] S_DEST    = 3'd2;
  localparam logic [2:0] S_SRC     = 3'd3;
  localparam logic [2:0] S_TYPE    = 3'd4;
  localparam logic [2:0] S_PAYLOAD = 3'd5;
  localparam logic [2:0] S_FCS     = 3'd6;
  localparam logic [2:0] S_CHECK   = 3'd7;

  localparam logic [47:0] BCAST_ADDR = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [31:0] CRC_POLY   = 32'hEDB8_8320;
  localparam logic [3:0]  PRE_MIN    = 4'(PREAMBLE_MIN);

  // One byte of reflected CRC-32, data bits taken LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] r;
    r = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // Index of the final byte of each capture state.
  function automatic logic [2:0] field_last(input logic [2:0] st);
    case (st)
      S_DEST, S_SRC:      field_last = 3'd5;
      S_TYPE:             field_last = 3'd1;
      S_PAYLOAD, S_FCS:   field_last = 3'd3;
      default:            field_last = 3'd0;
    endcase
  endfunction

  logic [2:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  pre_q, pre_d;
  logic [31:0] crc_q, crc_d;

  logic        frame_ok_q, frame_ok_d;
  logic        crc_err_q, crc_err_d;
  logic        addr_drop_q, addr_drop_d;
  logic        frame_abort_q, frame_abort_d;
  logic        rx_busy_q;

  logic [47:0] dest_q, src_q;
  logic [15:0] type_q;
  logic [31:0] pay_q;

  // Shadow copies of the frame being received; only committed on frame_ok.
  logic [47:0] dest_sh_q, src_sh_q;
  logic [15:0] type_sh_q;
  logic [31:0] pay_sh_q, fcs_sh_q;

  logic [7:0]  byte_w;
  logic        vld_w;

  assign byte_w = rx_if.rx_data;
  assign vld_w  = rx_if.rx_valid;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pre_d         = pre_q;
    crc_d         = crc_q;
    frame_ok_d    = 1'b0;
    crc_err_d     = 1'b0;
    addr_drop_d   = 1'b0;
    frame_abort_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (vld_w && byte_w == 8'h55) begin
          pre_d   = 4'd1;
          state_d = S_PRE;
        end
      end

      S_PRE: begin
        if (!vld_w) begin
          state_d = S_IDLE;
        end else if (byte_w == 8'h55) begin
          if (pre_q != 4'd15) pre_d = pre_q + 4'd1;
        end else if (byte_w == 8'hD5 && pre_q >= PRE_MIN) begin
          crc_d   = 32'hFFFF_FFFF;
          cnt_d   = 3'd0;
          state_d = S_DEST;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_DEST, S_SRC, S_TYPE, S_PAYLOAD, S_FCS: begin
        if (!vld_w) begin
          // No gaps are tolerated once the SFD has been seen.
          frame_abort_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          if (state_q != S_FCS) crc_d = crc32_byte(crc_q, byte_w);
          if (cnt_q == field_last(state_q)) begin
            cnt_d   = 3'd0;
            state_d = state_q + 3'd1;   // capture states are encoded in order
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      S_CHECK: begin
        if (fcs_sh_q != ~crc_q) begin
          crc_err_d = 1'b1;
        end else if (dest_sh_q != MAC_ADDR && dest_sh_q != BCAST_ADDR) begin
          addr_drop_d = 1'b1;
        end else begin
          frame_ok_d = 1'b1;
        end
        cnt_d   = 3'd0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (vld_w) begin
      case (state_q)
        S_DEST:    dest_sh_q <= {dest_sh_q[39:0], byte_w};
        S_SRC:     src_sh_q  <= {src_sh_q[39:0], byte_w};
        S_TYPE:    type_sh_q <= {type_sh_q[7:0], byte_w};
        S_PAYLOAD: pay_sh_q  <= {pay_sh_q[23:0], byte_w};
        S_FCS:     fcs_sh_q  <= {fcs_sh_q[23:0], byte_w};
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= 3'd0;
      pre_q         <= 4'd0;
      crc_q         <= 32'hFFFF_FFFF;
      frame_ok_q    <= 1'b0;
      crc_err_q     <= 1'b0;
      addr_drop_q   <= 1'b0;
      frame_abort_q <= 1'b0;
      rx_busy_q     <= 1'b0;
      dest_q        <= 48'd0;
      src_q         <= 48'd0;
      type_q        <= 16'd0;
      pay_q         <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pre_q         <= pre_d;
      crc_q         <= crc_d;
      frame_ok_q    <= frame_ok_d;
      crc_err_q     <= crc_err_d;
      addr_drop_q   <= addr_drop_d;
      frame_abort_q <= frame_abort_d;
      rx_busy_q     <= (state_d != S_IDLE);
      if (frame_ok_d) begin
        dest_q <= dest_sh_q;
        src_q  <= src_sh_q;
        type_q <= type_sh_q;
        pay_q  <= pay_sh_q;
      end
    end
  end

  assign rx_if.dest_addr   = dest_q;
  assign rx_if.src_addr    = src_q;
  assign rx_if.eth_type    = type_q;
  assign rx_if.payload     = pay_q;
  assign rx_if.frame_ok    = frame_ok_q;
  assign rx_if.crc_err     = crc_err_q;
  assign rx_if.addr_drop   = addr_drop_q;
  assign rx_if.frame_abort = frame_abort_q;
  assign rx_if.rx_busy     = rx_busy_q;

endmodule

// File: tb/tb_eth_frame_receiver.sv
// ---------------------------------------------------------------------------
// tb_eth_frame_receiver
// Purpose : self-checking bench for eth_frame_receiver. Frames are built as
//           byte lists, the FCS comes from a bit-serial CRC-32 model, and the
//           expected verdict/fields follow from the frame-level rules.
// ---------------------------------------------------------------------------
module tb_eth_frame_receiver;

  localparam logic [47:0] MAC   = 48'hAA_BB_CC_DD_EE_FF;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam int V_OK = 0, V_CRC = 1, V_DROP = 2, V_ABORT = 3, V_NONE = 4;

  logic clk;
  logic rst_n;

  eth_frame_receiver_if bus ();

  eth_frame_receiver dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Pulse monitor, sampled 1 time unit after each rising edge.
  int cyc = 0;
  int cnt_ok = 0, cnt_crc = 0, cnt_drop = 0, cnt_abort = 0;
  int last_ok_cyc = 0;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.frame_ok)    begin cnt_ok++; last_ok_cyc = cyc; end
    if (bus.crc_err)     cnt_crc++;
    if (bus.addr_drop)   cnt_drop++;
    if (bus.frame_abort) cnt_abort++;
  end

  // Byte stream to play: {valid, data}.
  logic [8:0] fq[$];

  // Reference state: what the outputs must hold.
  logic [47:0] exp_dest = '0, exp_src = '0;
  logic [15:0] exp_type = '0;
  logic [31:0] exp_pay  = '0;

  // Observations from the last play.
  int obs_ok, obs_crc, obs_drop, obs_abort, obs_lat;

  function automatic logic [31:0] model_fcs(input logic [7:0] b[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return ~c;
  endfunction

  function automatic int model_verdict(input int pre_n, input logic [47:0] d,
                                       input logic [31:0] fcs_xor, input int trunc);
    if (pre_n < 7)        return V_NONE;
    if (trunc < 22)       return V_ABORT;
    if (fcs_xor != 0)     return V_CRC;
    if (d != MAC && d != BCAST) return V_DROP;
    return V_OK;
  endfunction

  // Appends one frame to fq; trunc limits the body bytes (22 = whole frame).
  task automatic add_frame(input int pre_n, input logic [47:0] d, input logic [47:0] s,
                           input logic [15:0] t, input logic [31:0] p,
                           input logic [31:0] fcs_xor, input int trunc);
    logic [7:0]  body[$];
    logic [31:0] fcs;
    for (int i = 0; i < pre_n; i++) fq.push_back({1'b1, 8'h55});
    fq.push_back({1'b1, 8'hD5});
    for (int i = 5; i >= 0; i--) body.push_back(d[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) body.push_back(s[i*8 +: 8]);
    for (int i = 1; i >= 0; i--) body.push_back(t[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) body.push_back(p[i*8 +: 8]);
    fcs = model_fcs(body) ^ fcs_xor;
    for (int i = 3; i >= 0; i--) body.push_back(fcs[i*8 +: 8]);
    for (int i = 0; i < trunc && i < 22; i++) fq.push_back({1'b1, body[i]});
  endtask

  task automatic apply_model(input int v, input logic [47:0] d, input logic [47:0] s,
                             input logic [15:0] t, input logic [31:0] p);
    if (v == V_OK) begin
      exp_dest = d; exp_src = s; exp_type = t; exp_pay = p;
    end
  endtask

  // Plays fq, then idles with rx_valid low and records the pulses seen.
  task automatic play_frame();
    int b_ok, b_crc, b_drop, b_abort, end_cyc;
    b_ok = cnt_ok; b_crc = cnt_crc; b_drop = cnt_drop; b_abort = cnt_abort;
    foreach (fq[i]) begin
      @(negedge clk);
      bus.rx_valid = fq[i][8];
      bus.rx_data  = fq[i][7:0];
    end
    end_cyc = cyc;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (4) @(negedge clk);
    obs_ok    = cnt_ok - b_ok;
    obs_crc   = cnt_crc - b_crc;
    obs_drop  = cnt_drop - b_drop;
    obs_abort = cnt_abort - b_abort;
    obs_lat   = (obs_ok > 0) ? (last_ok_cyc - end_cyc) : -1;
    fq.delete();
  endtask

  function automatic int code_of(input int v);
    case (v)
      V_OK:    return 1000;
      V_CRC:   return 100;
      V_DROP:  return 10;
      V_ABORT: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if ({bus.dest_addr, bus.src_addr, bus.eth_type, bus.payload} !== 144'd0)
      $display("FAIL reset_fields got=%h want=0", {bus.dest_addr, bus.src_addr, bus.eth_type, bus.payload});
    else n_pass++;
    n_chk++; if ({bus.frame_ok, bus.crc_err, bus.addr_drop, bus.frame_abort, bus.rx_busy} !== 5'b0)
      $display("FAIL reset_ctrl got=%b want=00000",
               {bus.frame_ok, bus.crc_err, bus.addr_drop, bus.frame_abort, bus.rx_busy});
    else n_pass++;
  endtask

  task automatic test_good_broadcast();
    add_frame(7, BCAST, MAC, 16'h0800, 32'hDEAD_BEEF, 32'd0, 22);
    play_frame();
    apply_model(V_OK, BCAST, MAC, 16'h0800, 32'hDEAD_BEEF);
    n_chk++; if (obs_ok*1000 + obs_crc*100 + obs_drop*10 + obs_abort !== 1000)
      $display("FAIL bcast_pulses got=%0d%0d%0d%0d want=1000", obs_ok, obs_crc, obs_drop, obs_abort);
    else n_pass++;
    n_chk++; if (obs_lat !== 2) $display("FAIL bcast_latency got=%0d want=2", obs_lat);
    else n_pass++;
    n_chk++; if (bus.payload !== 32'hDEAD_BEEF) $display("FAIL bcast_payload got=%h want=deadbeef", bus.payload);
    else n_pass++;
    n_chk++; if (bus.eth_type !== 16'h0800) $display("FAIL bcast_type got=%h want=0800", bus.eth_type);
    else n_pass++;
    n_chk++; if (bus.src_addr !== 48'hAABBCCDDEEFF) $display("FAIL bcast_src got=%h want=aabbccddeeff", bus.src_addr);
    else n_pass++;
    n_chk++; if (bus.dest_addr !== BCAST) $display("FAIL bcast_dest got=%h want=%h", bus.dest_addr, BCAST);
    else n_pass++;
    n_chk++; if (bus.rx_busy !== 1'b0) $display("FAIL bcast_busy got=%b want=0", bus.rx_busy);
    else n_pass++;
  endtask

  task automatic test_crc_error();
    add_frame(7, BCAST, 48'h1122_3344_5566, 16'h86DD, 32'h0BAD_F00D, 32'd1, 22);
    play_frame();
    n_chk++; if (obs_ok*1000 + obs_crc*100 + obs_drop*10 + obs_abort !== 100)
      $display("FAIL crc_pulses got=%0d%0d%0d%0d want=0100", obs_ok, obs_crc, obs_drop, obs_abort);
    else n_pass++;
    n_chk++; if ({bus.dest_addr, bus.src_addr, bus.eth_type, bus.payload} !== {exp_dest, exp_src, exp_type, exp_pay})
      $display("FAIL crc_fields_held got=%h want=%h", {bus.dest_addr, bus.src_addr, bus.eth_type, bus.payload},
               {exp_dest, exp_src, exp_type, exp_pay});
    else n_pass++;
  endtask

  task automatic test_addr_drop();
    add_frame(7, 48'h01_02_03_04_05_06, 48'h1122_3344_5566, 16'h0806, 32'h1234_5678, 32'd0, 22);
    play_frame();
    n_chk++; if (obs_ok*1000 + obs_crc*100 + obs_drop*10 + obs_abort !== 10)
      $display("FAIL drop_pulses got=%0d%0d%0d%0d want=0010", obs_ok, obs_crc, obs_drop, obs_abort);
    else n_pass++;
    n_chk++; if ({bus.dest_addr, bus.src_addr, bus.eth_type, bus.payload} !== {exp_dest, exp_src, exp_type, exp_pay})
      $display("FAIL drop_fields_held got=%h want=%h", {bus.dest_addr, bus.src_addr, bus.eth_type, bus.payload},
               {exp_dest, exp_src, exp_type, exp_pay});
    else n_pass++;
  endtask

  task automatic test_short_preamble();
    add_frame(5, BCAST, MAC, 16'h0800, 32'hDEAD_BEEF, 32'd0, 22);
    play_frame();
    n_chk++; if (obs_ok + obs_crc + obs_drop + obs_abort !== 0)
      $display("FAIL shortpre_pulses got=%0d want=0", obs_ok + obs_crc + obs_drop + obs_abort);
    else n_pass++;
    n_chk++; if (bus.rx_busy !== 1'b0) $display("FAIL shortpre_busy got=%b want=0", bus.rx_busy);
    else n_pass++;
    add_frame(7, MAC, 48'h0A0B_0C0D_0E0F, 16'h0801, 32'hCAFE_F00D, 32'd0, 22);
    play_frame();
    apply_model(V_OK, MAC, 48'h0A0B_0C0D_0E0F, 16'h0801, 32'hCAFE_F00D);
    n_chk++; if (obs_ok !== 1) $display("FAIL shortpre_next_ok got=%0d want=1", obs_ok);
    else n_pass++;
    n_chk++; if (bus.payload !== 32'hCAFE_F00D) $display("FAIL shortpre_next_payload got=%h want=cafef00d", bus.payload);
    else n_pass++;
  endtask

  task automatic test_abort();
    // 8 + 18 - 1 bytes: up to and including the 3rd payload byte, then a gap.
    add_frame(7, BCAST, 48'h0102_0304_0506, 16'h0800, 32'h5A5A_A5A5, 32'd0, 17);
    fq.push_back({1'b0, 8'h00});
    add_frame(7, MAC, 48'h6655_4433_2211, 16'h88B5, 32'h0123_4567, 32'd0, 22);
    play_frame();
    apply_model(V_OK, MAC, 48'h6655_4433_2211, 16'h88B5, 32'h0123_4567);
    n_chk++; if (obs_ok*1000 + obs_crc*100 + obs_drop*10 + obs_abort !== 1001)
      $display("FAIL abort_pulses got=%0d%0d%0d%0d want=1001", obs_ok, obs_crc, obs_drop, obs_abort);
    else n_pass++;
    n_chk++; if ({bus.dest_addr, bus.src_addr, bus.eth_type, bus.payload} !== {exp_dest, exp_src, exp_type, exp_pay})
      $display("FAIL abort_next_fields got=%h want=%h", {bus.dest_addr, bus.src_addr, bus.eth_type, bus.payload},
               {exp_dest, exp_src, exp_type, exp_pay});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    // A filler byte lands in the verdict cycle; the next frame follows directly.
    add_frame(7, BCAST, 48'h1111_2222_3333, 16'h0800, 32'h1111_1111, 32'd0, 22);
    fq.push_back({1'b1, 8'h55});
    add_frame(7, MAC, 48'h4444_5555_6666, 16'h0806, 32'h2222_2222, 32'd0, 22);
    play_frame();
    apply_model(V_OK, MAC, 48'h4444_5555_6666, 16'h0806, 32'h2222_2222);
    n_chk++; if (obs_ok !== 2) $display("FAIL b2b_ok_count got=%0d want=2", obs_ok);
    else n_pass++;
    n_chk++; if (bus.payload !== 32'h2222_2222) $display("FAIL b2b_payload got=%h want=22222222", bus.payload);
    else n_pass++;
    // No filler: the first 0x55 of the second frame is swallowed by the
    // verdict cycle, leaving only 6 counted preamble bytes.
    add_frame(7, BCAST, 48'h7777_8888_9999, 16'h0800, 32'h3333_3333, 32'd0, 22);
    add_frame(7, MAC, 48'hAAAA_0000_BBBB, 16'h0800, 32'h4444_4444, 32'd0, 22);
    play_frame();
    apply_model(V_OK, BCAST, 48'h7777_8888_9999, 16'h0800, 32'h3333_3333);
    n_chk++; if (obs_ok*1000 + obs_crc*100 + obs_drop*10 + obs_abort !== 1000)
      $display("FAIL b2b_check_cycle got=%0d%0d%0d%0d want=1000", obs_ok, obs_crc, obs_drop, obs_abort);
    else n_pass++;
    n_chk++; if (bus.payload !== 32'h3333_3333) $display("FAIL b2b_check_payload got=%h want=33333333", bus.payload);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] r1, r2, r3, r4, fx;
    logic [47:0] d, s;
    int pre_n, trunc, v, sel;
    for (int n = 0; n < 30; n++) begin
      r1 = $urandom(); r2 = $urandom(); r3 = $urandom(); r4 = $urandom();
      sel = $urandom_range(0, 3);
      case (sel)
        0:       d = MAC;
        1:       d = BCAST;
        2:       d = {r1, r2[15:0]};
        default: d = MAC ^ (48'd1 << $urandom_range(0, 47));
      endcase
      s     = {r2, r3[15:0]};
      pre_n = $urandom_range(5, 20);
      fx    = ($urandom_range(0, 3) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'd0;
      trunc = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 21) : 22;
      v     = model_verdict(pre_n, d, fx, trunc);
      add_frame(pre_n, d, s, r3[31:16], r4, fx, trunc);
      play_frame();
      apply_model(v, d, s, r3[31:16], r4);
      n_chk++; if (obs_ok*1000 + obs_crc*100 + obs_drop*10 + obs_abort !== code_of(v))
        $display("FAIL rand%0d_pulses got=%0d%0d%0d%0d want=%04d", n, obs_ok, obs_crc, obs_drop, obs_abort, code_of(v));
      else n_pass++;
      n_chk++; if ({bus.dest_addr, bus.src_addr, bus.eth_type, bus.payload} !== {exp_dest, exp_src, exp_type, exp_pay})
        $display("FAIL rand%0d_fields got=%h want=%h", n, {bus.dest_addr, bus.src_addr, bus.eth_type, bus.payload},
                 {exp_dest, exp_src, exp_type, exp_pay});
      else n_pass++;
      if (v == V_OK) begin
        n_chk++; if (obs_lat !== 2) $display("FAIL rand%0d_latency got=%0d want=2", n, obs_lat);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int b_sum;
    // Preamble, SFD, destination and two source bytes: receiver is in SRC.
    add_frame(7, MAC, 48'hDEAD_0000_BEEF, 16'h0800, 32'h9999_9999, 32'd0, 8);
    foreach (fq[i]) begin
      @(negedge clk);
      bus.rx_valid = fq[i][8];
      bus.rx_data  = fq[i][7:0];
    end
    fq.delete();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++; if ({bus.dest_addr, bus.src_addr, bus.eth_type, bus.payload} !== 144'd0)
      $display("FAIL rstmid_fields got=%h want=0", {bus.dest_addr, bus.src_addr, bus.eth_type, bus.payload});
    else n_pass++;
    n_chk++; if (bus.rx_busy !== 1'b0) $display("FAIL rstmid_busy got=%b want=0", bus.rx_busy);
    else n_pass++;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    exp_dest = '0; exp_src = '0; exp_type = '0; exp_pay = '0;
    b_sum = cnt_ok + cnt_crc + cnt_drop + cnt_abort;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    n_chk++; if (cnt_ok + cnt_crc + cnt_drop + cnt_abort - b_sum !== 0)
      $display("FAIL rstmid_pulses got=%0d want=0", cnt_ok + cnt_crc + cnt_drop + cnt_abort - b_sum);
    else n_pass++;
    n_chk++; if ({bus.dest_addr, bus.src_addr, bus.eth_type, bus.payload, bus.rx_busy} !== 145'd0)
      $display("FAIL rstmid_after got=%h want=0", {bus.dest_addr, bus.src_addr, bus.eth_type, bus.payload, bus.rx_busy});
    else n_pass++;
    // Receiver recovers for the next frame.
    add_frame(8, BCAST, 48'h0001_0002_0003, 16'h0800, 32'hFEED_FACE, 32'd0, 22);
    play_frame();
    n_chk++; if (obs_ok !== 1 || bus.payload !== 32'hFEED_FACE)
      $display("FAIL rstmid_recover got=%0d/%h want=1/feedface", obs_ok, bus.payload);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_good_broadcast();
    test_crc_error();
    test_addr_drop();
    test_short_preamble();
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/eth_frame_receiver.md
# eth_frame_receiver

Byte-stream Ethernet frame receiver: the receive-side counterpart of the frame transmitter. It hunts for preamble/SFD, de-serialises destination address, source address, EtherType and a fixed 4-byte payload, and checks the trailing FCS against an internally computed CRC-32. It applies a destination-address filter and hands accepted frames to the upper layer as parallel fields with a one-cycle strobe.

## Interface
- `MAC_ADDR`, default 48'hAA_BB_CC_DD_EE_FF: station address; a frame is accepted if its destination equals this or is broadcast 48'hFF_FF_FF_FF_FF_FF.
- `PREAMBLE_MIN`, default 7: minimum number of 0x55 bytes required before 0xD5.
- `clk` input 1: single clock, all logic on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rx_data` input 8: received byte.
- `rx_valid` input 1: `rx_data` is valid this cycle.
- `dest_addr` output 48: destination of last accepted frame, first received byte in [47:40].
- `src_addr` output 48: source of last accepted frame, same ordering.
- `eth_type` output 16: EtherType, first byte in [15:8].
- `payload` output 32: payload, first byte in [31:24].
- `frame_ok` output 1: one-cycle pulse; the field outputs were updated this cycle.
- `crc_err` output 1: one-cycle pulse; FCS mismatch, frame discarded.
- `addr_drop` output 1: one-cycle pulse; CRC good but address filtered, frame discarded.
- `frame_abort` output 1: one-cycle pulse; `rx_valid` dropped mid-frame.
- `rx_busy` output 1: high in every state except IDLE.

## Operation
- States: IDLE, PREAMBLE, DEST, SRC, TYPE, PAYLOAD, FCS, CHECK.
- Bytes are consumed only on cycles with `rx_valid`=1.
- IDLE: on 0x55, set preamble count to 1 and go to PREAMBLE. Any other byte is ignored.
- PREAMBLE:
  - 0x55: increment the count, saturating at 15.
  - 0xD5 with count ≥ `PREAMBLE_MIN`: clear the CRC and go to DEST.
  - 0xD5 with count too low, or any other byte: return to IDLE silently, with no pulse.
  - `rx_valid` low: return to IDLE silently.
- Field capture counts: DEST 6 bytes, SRC 6, TYPE 2, PAYLOAD 4, FCS 4. Each uses a byte counter that resets at every state change.
- Captured bytes go into shadow registers. The output registers change only on `frame_ok`.
- CRC-32 (IEEE, reflected poly 0xEDB88320):
  - Register initialised to 0xFFFFFFFF on SFD acceptance.
  - Updated with each byte accepted in DEST/SRC/TYPE/PAYLOAD, processed LSB-first.
  - Expected FCS is the bitwise complement of the register after the last payload byte.
- FCS bytes are assembled most-significant byte first into a 32-bit value.
- CHECK is a single cycle with no byte consumed:
  - If the FCS mismatches, pulse `crc_err`.
  - Else if the destination is not `MAC_ADDR` and not broadcast, pulse `addr_drop`.
  - Else pulse `frame_ok` and commit the shadow registers to the outputs.
  - Go to IDLE.
- `rx_valid`=0 in DEST..FCS: pulse `frame_abort`, go to IDLE, and leave the outputs unchanged.
- Exactly one of `frame_ok`/`crc_err`/`addr_drop`/`frame_abort` pulses per frame that passed SFD. None pulse for preamble failures.
- Reset mid-frame: immediate return to IDLE, all outputs to reset values, and no pulse after release.

## Timing
- Reset values: all field outputs 0, all pulses 0, `rx_busy` 0, state IDLE, CRC register 0xFFFFFFFF.
- All outputs are registered.
- Verdict pulse appears 2 cycles after the cycle carrying the last FCS byte: FCS→CHECK on the first edge, outputs registered on the second.
- Field outputs and `frame_ok` change on the same edge.
- Back-to-back frames: IDLE accepts a new 0x55 on the cycle following CHECK. A 0x55 presented during the CHECK cycle is ignored.
- Inter-byte gaps are not supported. Any gap after SFD is an abort.
- Minimum frame occupancy after SFD is 18 data + 4 FCS bytes + 1 CHECK cycle.

## Test plan
- Good broadcast frame: 7×0x55, 0xD5, dest FF…FF, src AA_BB_CC_DD_EE_FF, type 0x0800, payload 0xDEADBEEF, correct FCS from the bench model. Required: `frame_ok` pulses once 2 cycles after the last FCS byte; `payload`=0xDEADBEEF, `eth_type`=0x0800, `src_addr`=48'hAABBCCDDEEFF.
- Same frame with FCS bit 0 flipped: `crc_err` pulses once; outputs keep their previous values.
- Good-CRC frame to dest 01_02_03_04_05_06 with default `MAC_ADDR`: `addr_drop` pulses; outputs unchanged.
- Preamble of 5×0x55 then 0xD5, followed by a valid frame body: no pulse, `rx_busy` returns to 0; a following correct frame yields `frame_ok`.
- `rx_valid` dropped for 1 cycle after the 3rd payload byte: `frame_abort` pulses; a subsequent good frame starting 1 cycle later is received with `frame_ok`.
- `rst_n` asserted during SRC: all outputs 0 immediately; after release with `rx_valid`=0, no pulse ever appears.
